multi_port_queue: RTL and testbench
===================================

Name: multi_port_queue

Overview:
- Parametrised circular FIFO with a configurable number of push and pop lanes per cycle, so superscalar dispatch and retire stages can move several entries each clock.
- Adds a tail rollback for branch-mispredict recovery, while keeping the synchronous flush and the index probe read/write.
- Intended for ROB, free-list and issue-buffer instances in the out-of-order core.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- ADDR_WIDTH, 4, pointer bits; depth MAX_BUF = 2**ADDR_WIDTH.
- PUSH_LANES, 2, max entries pushed per cycle (>=1).
- POP_LANES, 2, max entries popped per cycle (>=1).
- INIT_CODE, 0, reset contents: 0 = all zero, empty; 1 = buffer[i]=i, count=MAX_BUF (free-list mode).
- CW_PUSH, clog2(PUSH_LANES+1), width of push count.
- CW_POP, clog2(POP_LANES+1), width of pop count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pushCnt_IN  in  CW_PUSH  entries to push this cycle, lanes 0..pushCnt-1.
- data_IN  in  PUSH_LANES*DATA_WIDTH  push data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- pushAck_OUT  out  1  push accepted this cycle (combinational).
- popCnt_IN  in  CW_POP  entries requested to pop.
- popGrant_OUT  out  CW_POP  entries actually popped = min(popCnt_IN, count) (combinational).
- data_OUT  out  POP_LANES*DATA_WIDTH  lane i = buffer[head+i], combinational.
- popValid_OUT  out  POP_LANES  bit i = (i < count).
- flush_IN  in  1  synchronous empty.
- rollback_IN  in  1  restore tail.
- rollbackTail_IN  in  ADDR_WIDTH  tail value to restore.
- emptyFlag_OUT  out  1  count==0.
- fullFlag_OUT  out  1  count==MAX_BUF.
- count_OUT  out  ADDR_WIDTH+1  occupancy.
- freeCnt_OUT  out  ADDR_WIDTH+1  MAX_BUF-count.
- curHead_OUT  out  ADDR_WIDTH  head pointer.
- curTail_OUT  out  ADDR_WIDTH  tail pointer.
- probeIdx_IN  in  ADDR_WIDTH  probe index.
- probeData_OUT  out  DATA_WIDTH  buffer[probeIdx_IN], combinational.
- probePushReq_IN  in  1  probe write enable.
- probeData_IN  in  DATA_WIDTH  probe write data.

Behaviour:
- Reset (async, reset==0):
  - head=tail=0.
  - INIT_CODE=0: count=0, buffer all 0.
  - INIT_CODE=1: count=MAX_BUF, buffer[i]=i.
  - Resulting outputs: pushAck=0 until pushCnt>0, popGrant=0 (INIT_CODE=0), flags follow count.
  - Reset asserted mid-operation discards all state immediately.
- Push is all-or-nothing: pushAck_OUT = (pushCnt_IN!=0) && (pushCnt_IN <= freeCnt) && !flush_IN && !rollback_IN.
  - When acked, buffer[tail+i] <= lane i for i<pushCnt, and tail += pushCnt, at the next edge.
  - Free space is evaluated before same-cycle pops; a pop does not make room for a push in the same cycle.
- Pop: grant g = min(popCnt_IN, count), or 0 when flush_IN=1. head += g at the next edge.
  - Data is valid combinationally in the same cycle.
- Count: count_next = count + pushed - g. The pushed-and-popped case is exact; no bias.
- Wrap-around: all pointer and index arithmetic is modulo MAX_BUF.
  - Count width ADDR_WIDTH+1 distinguishes full from empty.
- Priority: reset > flush > rollback > normal.
  - flush_IN: head=tail=count=0; push and pop ignored; buffer contents kept. This holds even when INIT_CODE=1.
  - rollback_IN:
    - Push is blocked; pops still apply.
    - tail <= rollbackTail_IN.
    - rollbackTail_IN must lie in [head+g, tail] circularly; other values are undefined usage and the bench must not drive them.
    - count_next = (rollbackTail_IN - (head+g)) mod MAX_BUF.
    - Exception: if rollbackTail_IN == tail, then count_next = count - g, which preserves full.
- Probe write: buffer[probeIdx_IN] <= probeData_IN at the edge. A same-cycle push lane writing the same index wins.
  - Probe writes do not touch pointers or count.
- Probe read and data_OUT reflect current array contents, not the values being written this cycle. There is no bypass.
- popCnt_IN > POP_LANES and pushCnt_IN > PUSH_LANES are illegal inputs.

Decomposition:
- Include file multi_port_queue_defs.vh:
  - MAX_BUF macro.
  - Count-width helper function (clog2).
  - INIT_CODE encodings QINIT_ZERO=0, QINIT_IDX=1.
- Sub-module queue_ptr_ctrl: head/tail/count registers, grant/ack computation, flush/rollback priority.
- The storage array and lane muxing stay in the top module.

Test Plan:
- ADDR_WIDTH=3, lanes 2/2, INIT_CODE=0: push 2 per cycle for 4 cycles -> count 8, full=1. 5th push of 1 -> pushAck=0, count remains 8.
- Full queue, popCnt=2 and pushCnt=2 same cycle -> pushAck=0, popGrant=2, count 6. Next cycle the push is acked -> count 8. Check tail wraps to 0 and data order is preserved.
- count=1, popCnt=2 -> popGrant=1, popValid=01, emptyFlag=1 next cycle.
- Pushes with head=2, tail=7, then rollback_IN with rollbackTail=4 and popCnt=1 -> head=3, tail=4, count=1. Then rollbackTail==tail on a full queue -> count stays 8.
- INIT_CODE=1: after reset, count=8 and data_OUT lanes = 0,1. Pulse flush -> count=0, empty=1. Probe read of idx 5 still returns 5.
- Probe write idx 3 = 0xAB in the same cycle as a push to tail=3 with 0x11 -> buffer[3]=0x11. Assert reset asynchronously between edges -> count and pointers clear immediately.

Source files
------------

// File: rtl/multi_port_queue_pkg.sv
// Shared constants and sizing helpers for the multi-lane circular queue.
// Reset-content encodings select an empty queue or a full free-list of indices.
package multi_port_queue_pkg;

  localparam int QINIT_ZERO = 0;
  localparam int QINIT_IDX  = 1;

  // Bits needed to encode a lane count in 0..lanes.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic int buf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/queue_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping: push acceptance, pop grant, and the
// flush > rollback > normal update priority.
module queue_ptr_ctrl
  import multi_port_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int PUSH_LANES = 2,
  parameter int POP_LANES  = 2,
  parameter int INIT_CODE  = QINIT_ZERO,
  parameter int CW_PUSH    = cnt_width(PUSH_LANES),
  parameter int CW_POP     = cnt_width(POP_LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW_PUSH-1:0]    push_cnt,
  input  logic [CW_POP-1:0]     pop_cnt,
  input  logic                  flush,
  input  logic                  rollback,
  input  logic [ADDR_WIDTH-1:0] rollback_tail,
  output logic                  push_ack,
  output logic [CW_POP-1:0]     pop_grant,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int MAX_BUF = buf_depth(ADDR_WIDTH);
  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_BUF);

  logic [CNT_W-1:0]      free_cnt;
  logic [CNT_W-1:0]      push_w;
  logic [CNT_W-1:0]      grant_w;
  logic [CNT_W-1:0]      count_after_pop;
  logic [ADDR_WIDTH-1:0] head_next;
  logic [ADDR_WIDTH-1:0] rb_dist;

  // Free space is judged on the pre-pop count, so a pop never frees room
  // for a push in the same cycle.
  always_comb begin
    free_cnt = FULL_CNT - count;
    push_w   = CNT_W'(push_cnt);
    grant_w  = CNT_W'(pop_cnt);
    push_ack = (push_cnt != '0) && (push_w <= free_cnt) && !flush && !rollback;
    if (flush)
      grant_w = '0;
    else if (grant_w > count)
      grant_w = count;
    pop_grant       = CW_POP'(grant_w);
    head_next       = head + ADDR_WIDTH'(grant_w);
    count_after_pop = count - grant_w;
    rb_dist         = rollback_tail - head_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= (INIT_CODE == QINIT_IDX) ? FULL_CNT : '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head_next;
      if (rollback) begin
        tail <= rollback_tail;
        // Restoring the current tail keeps a full queue full instead of
        // aliasing to zero through the modulo distance.
        count <= (rollback_tail == tail) ? count_after_pop : {1'b0, rb_dist};
      end else if (push_ack) begin
        tail  <= tail + ADDR_WIDTH'(push_cnt);
        count <= count_after_pop + push_w;
      end else begin
        count <= count_after_pop;
      end
    end
  end

endmodule

// File: rtl/multi_port_queue.sv
// Multi-lane circular FIFO with tail rollback, flush and an index probe port.
// Storage and lane muxing live here; pointer control is in queue_ptr_ctrl.
module multi_port_queue
  import multi_port_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PUSH_LANES = 2,
  parameter int POP_LANES  = 2,
  parameter int INIT_CODE  = QINIT_ZERO,
  parameter int CW_PUSH    = cnt_width(PUSH_LANES),
  parameter int CW_POP     = cnt_width(POP_LANES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CW_PUSH-1:0]               pushCnt_IN,
  input  logic [PUSH_LANES*DATA_WIDTH-1:0] data_IN,
  output logic                             pushAck_OUT,
  input  logic [CW_POP-1:0]                popCnt_IN,
  output logic [CW_POP-1:0]                popGrant_OUT,
  output logic [POP_LANES*DATA_WIDTH-1:0]  data_OUT,
  output logic [POP_LANES-1:0]             popValid_OUT,
  input  logic                             flush_IN,
  input  logic                             rollback_IN,
  input  logic [ADDR_WIDTH-1:0]            rollbackTail_IN,
  output logic                             emptyFlag_OUT,
  output logic                             fullFlag_OUT,
  output logic [ADDR_WIDTH:0]              count_OUT,
  output logic [ADDR_WIDTH:0]              freeCnt_OUT,
  output logic [ADDR_WIDTH-1:0]            curHead_OUT,
  output logic [ADDR_WIDTH-1:0]            curTail_OUT,
  input  logic [ADDR_WIDTH-1:0]            probeIdx_IN,
  output logic [DATA_WIDTH-1:0]            probeData_OUT,
  input  logic                             probePushReq_IN,
  input  logic [DATA_WIDTH-1:0]            probeData_IN
);

  localparam int MAX_BUF = buf_depth(ADDR_WIDTH);
  localparam int CNT_W   = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] buffer [MAX_BUF];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CNT_W-1:0]      count;

  queue_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PUSH_LANES (PUSH_LANES),
    .POP_LANES  (POP_LANES),
    .INIT_CODE  (INIT_CODE),
    .CW_PUSH    (CW_PUSH),
    .CW_POP     (CW_POP)
  ) u_ptr (
    .clk           (clk),
    .reset         (reset),
    .push_cnt      (pushCnt_IN),
    .pop_cnt       (popCnt_IN),
    .flush         (flush_IN),
    .rollback      (rollback_IN),
    .rollback_tail (rollbackTail_IN),
    .push_ack      (pushAck_OUT),
    .pop_grant     (popGrant_OUT),
    .head          (head),
    .tail          (tail),
    .count         (count)
  );

  // Push lanes are written after the probe so they win on an index clash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_BUF; i++)
        buffer[i] <= (INIT_CODE == QINIT_IDX) ? DATA_WIDTH'(i) : '0;
    end else begin
      if (probePushReq_IN)
        buffer[probeIdx_IN] <= probeData_IN;
      if (pushAck_OUT) begin
        for (int i = 0; i < PUSH_LANES; i++)
          if (CW_PUSH'(i) < pushCnt_IN)
            buffer[tail + ADDR_WIDTH'(i)] <= data_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    data_OUT     = '0;
    popValid_OUT = '0;
    for (int i = 0; i < POP_LANES; i++) begin
      data_OUT[i*DATA_WIDTH +: DATA_WIDTH] = buffer[head + ADDR_WIDTH'(i)];
      popValid_OUT[i] = CNT_W'(i) < count;
    end
  end

  assign probeData_OUT = buffer[probeIdx_IN];
  assign emptyFlag_OUT = (count == '0);
  assign fullFlag_OUT  = (count == CNT_W'(MAX_BUF));
  assign count_OUT     = count;
  assign freeCnt_OUT   = CNT_W'(MAX_BUF) - count;
  assign curHead_OUT   = head;
  assign curTail_OUT   = tail;

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed and randomized checks of multi_port_queue against an array/occupancy
// reference model; a second instance covers the index-initialised free-list mode.
module tb_multi_port_queue;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int PL = 2;
  localparam int OL = 2;
  localparam int DEPTH = 8;
  localparam int CP = 2;
  localparam int CO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [CP-1:0] push_cnt;
  logic [PL*DW-1:0] data_in;
  logic          push_ack;
  logic [CO-1:0] pop_cnt;
  logic [CO-1:0] pop_grant;
  logic [OL*DW-1:0] data_out;
  logic [OL-1:0] pop_valid;
  logic          flush;
  logic          rollback;
  logic [AW-1:0] rb_tail;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   free_cnt;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] probe_idx;
  logic [DW-1:0] probe_out;
  logic          probe_we;
  logic [DW-1:0] probe_in;

  logic          flush2;
  logic [AW-1:0] probe_idx2;
  logic          push_ack2;
  logic [CO-1:0] pop_grant2;
  logic [OL*DW-1:0] data_out2;
  logic [OL-1:0] pop_valid2;
  logic          empty2;
  logic          full2;
  logic [AW:0]   count2;
  logic [AW:0]   free_cnt2;
  logic [AW-1:0] head2;
  logic [AW-1:0] tail2;
  logic [DW-1:0] probe_out2;

  multi_port_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PUSH_LANES(PL), .POP_LANES(OL), .INIT_CODE(0)
  ) dut (
    .clk(clk), .reset(reset), .pushCnt_IN(push_cnt), .data_IN(data_in),
    .pushAck_OUT(push_ack), .popCnt_IN(pop_cnt), .popGrant_OUT(pop_grant),
    .data_OUT(data_out), .popValid_OUT(pop_valid), .flush_IN(flush),
    .rollback_IN(rollback), .rollbackTail_IN(rb_tail), .emptyFlag_OUT(empty),
    .fullFlag_OUT(full), .count_OUT(count), .freeCnt_OUT(free_cnt),
    .curHead_OUT(head), .curTail_OUT(tail), .probeIdx_IN(probe_idx),
    .probeData_OUT(probe_out), .probePushReq_IN(probe_we), .probeData_IN(probe_in)
  );

  multi_port_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PUSH_LANES(PL), .POP_LANES(OL), .INIT_CODE(1)
  ) dut_idx (
    .clk(clk), .reset(reset), .pushCnt_IN('0), .data_IN('0),
    .pushAck_OUT(push_ack2), .popCnt_IN('0), .popGrant_OUT(pop_grant2),
    .data_OUT(data_out2), .popValid_OUT(pop_valid2), .flush_IN(flush2),
    .rollback_IN(1'b0), .rollbackTail_IN('0), .emptyFlag_OUT(empty2),
    .fullFlag_OUT(full2), .count_OUT(count2), .freeCnt_OUT(free_cnt2),
    .curHead_OUT(head2), .curTail_OUT(tail2), .probeIdx_IN(probe_idx2),
    .probeData_OUT(probe_out2), .probePushReq_IN(1'b0), .probeData_IN('0)
  );

  // Reference model: contents array plus head index and occupancy; tail is derived.
  logic [DW-1:0] m_mem [DEPTH];
  int m_head;
  int m_cnt;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_head = 0;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive(input int pc, input int pop, input bit fl, input bit rb, input int rbt);
    push_cnt = CP'(pc);
    pop_cnt  = CO'(pop);
    flush    = fl;
    rollback = rb;
    rb_tail  = AW'(rbt);
    data_in  = {$urandom, $urandom};
  endtask

  task automatic set_probe(input bit we, input int idx, input logic [DW-1:0] d);
    probe_we  = we;
    probe_idx = AW'(idx);
    probe_in  = d;
  endtask

  task automatic check_outputs(input string tag, input bit ack, input int g);
    logic [OL-1:0] pv;
    int tl;
    tl = (m_head + m_cnt) % DEPTH;
    for (int l = 0; l < OL; l++) pv[l] = (l < m_cnt);
    chk({tag, ".ack"},   push_ack, ack);
    chk({tag, ".grant"}, pop_grant, g);
    chk({tag, ".count"}, count, m_cnt);
    chk({tag, ".free"},  free_cnt, DEPTH - m_cnt);
    chk({tag, ".empty"}, empty, m_cnt == 0);
    chk({tag, ".full"},  full, m_cnt == DEPTH);
    chk({tag, ".head"},  head, m_head);
    chk({tag, ".tail"},  tail, tl);
    chk({tag, ".valid"}, pop_valid, pv);
    for (int l = 0; l < OL; l++)
      chk($sformatf("%s.lane%0d", tag, l), data_out[l*DW +: DW], m_mem[(m_head + l) % DEPTH]);
    chk({tag, ".probe"}, probe_out, m_mem[probe_idx]);
  endtask

  // Check this cycle's combinational view, clock once, then advance the model.
  task automatic step(input string tag);
    bit ack;
    int g, tl, nh, pc;
    #1;
    pc  = int'(push_cnt);
    tl  = (m_head + m_cnt) % DEPTH;
    ack = (pc != 0) && (pc <= DEPTH - m_cnt) && !flush && !rollback;
    g   = flush ? 0 : min_int(int'(pop_cnt), m_cnt);
    check_outputs(tag, ack, g);
    @(posedge clk);
    if (probe_we) m_mem[probe_idx] = probe_in;
    if (ack)
      for (int i = 0; i < pc; i++) m_mem[(tl + i) % DEPTH] = data_in[i*DW +: DW];
    if (flush) begin
      m_head = 0;
      m_cnt  = 0;
    end else if (rollback) begin
      nh = (m_head + g) % DEPTH;
      if (int'(rb_tail) == tl) m_cnt = m_cnt - g;
      else m_cnt = (int'(rb_tail) - nh + DEPTH) % DEPTH;
      m_head = nh;
    end else begin
      m_head = (m_head + g) % DEPTH;
      m_cnt  = m_cnt + (ack ? pc : 0) - g;
    end
    #1;
  endtask

  initial begin
    int pc, pop, g, rbt;
    bit fl, rb;

    reset = 1'b0;
    flush2 = 1'b0;
    probe_idx2 = AW'(5);
    drive(0, 0, 0, 0, 0);
    set_probe(0, 0, '0);
    model_reset();
    #12;
    reset = 1'b1;
    #1;
    check_outputs("reset", 1'b0, 0);

    chk("idx_rst.count", count2, 8);
    chk("idx_rst.full", full2, 1);
    chk("idx_rst.empty", empty2, 0);
    chk("idx_rst.free", free_cnt2, 0);
    chk("idx_rst.head", head2, 0);
    chk("idx_rst.tail", tail2, 0);
    chk("idx_rst.ack", push_ack2, 0);
    chk("idx_rst.grant", pop_grant2, 0);
    chk("idx_rst.valid", pop_valid2, 2'b11);
    chk("idx_rst.lane0", data_out2[0 +: DW], 0);
    chk("idx_rst.lane1", data_out2[DW +: DW], 1);
    chk("idx_rst.probe5", probe_out2, 5);
    @(posedge clk);
    #1;
    flush2 = 1'b1;
    @(posedge clk);
    #1;
    flush2 = 1'b0;
    chk("idx_flush.count", count2, 0);
    chk("idx_flush.empty", empty2, 1);
    chk("idx_flush.probe5", probe_out2, 5);
    chk("idx_flush.valid", pop_valid2, 2'b00);

    // Fill with two per cycle, then overflow attempt.
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 0, 0, 0);
      step("fill");
    end
    chk("fill.count8", count, 8);
    chk("fill.full", full, 1);
    chk("fill.tail_wrap", tail, 0);
    drive(1, 0, 0, 0, 0);
    step("overflow");
    chk("overflow.count", count, 8);

    // Pop does not make room for a same-cycle push.
    drive(2, 2, 0, 0, 0);
    #1;
    chk("full_pp.ack", push_ack, 0);
    chk("full_pp.grant", pop_grant, 2);
    step("full_pp");
    chk("full_pp.count6", count, 6);
    drive(2, 0, 0, 0, 0);
    step("refill");
    chk("refill.count8", count, 8);

    // Drain down to one then over-request.
    for (int i = 0; i < 3; i++) begin
      drive(0, 2, 0, 0, 0);
      step("drain");
    end
    drive(0, 1, 0, 0, 0);
    step("drain1");
    drive(0, 2, 0, 0, 0);
    #1;
    chk("last.grant1", pop_grant, 1);
    chk("last.valid01", pop_valid, 2'b01);
    step("last");
    chk("last.empty", empty, 1);

    // Rollback with concurrent pop, then rollback to current tail while full.
    drive(0, 0, 1, 0, 0);
    step("flush_a");
    drive(2, 0, 0, 0, 0); step("rb_fill");
    drive(2, 0, 0, 0, 0); step("rb_fill");
    drive(2, 0, 0, 0, 0); step("rb_fill");
    drive(1, 0, 0, 0, 0); step("rb_fill");
    drive(0, 2, 0, 0, 0); step("rb_pop");
    chk("rb_pre.head", head, 2);
    chk("rb_pre.tail", tail, 7);
    drive(1, 1, 0, 1, 4);
    step("rb");
    chk("rb.head3", head, 3);
    chk("rb.tail4", tail, 4);
    chk("rb.count1", count, 1);
    drive(2, 0, 0, 0, 0); step("rb_refill");
    drive(2, 0, 0, 0, 0); step("rb_refill");
    drive(2, 0, 0, 0, 0); step("rb_refill");
    drive(1, 0, 0, 0, 0); step("rb_refill");
    drive(0, 0, 0, 1, int'(tail));
    step("rb_full");
    chk("rb_full.count8", count, 8);

    // Push lane beats probe write on the same index.
    drive(0, 0, 1, 0, 0); step("flush_b");
    drive(2, 0, 0, 0, 0); step("pr_fill");
    drive(1, 0, 0, 0, 0); step("pr_fill");
    drive(1, 0, 0, 0, 0);
    data_in[0 +: DW] = 32'h11;
    set_probe(1, 3, 32'hAB);
    step("pr_clash");
    drive(0, 0, 0, 0, 0);
    set_probe(0, 3, '0);
    #1;
    chk("pr_clash.buf3", probe_out, 32'h11);
    step("pr_idle");

    // Asynchronous reset between edges clears state at once.
    #2;
    reset = 1'b0;
    #1;
    chk("areset.count", count, 0);
    chk("areset.head", head, 0);
    chk("areset.tail", tail, 0);
    chk("areset.probe3", probe_out, 0);
    model_reset();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      pc  = $urandom_range(0, 2);
      pop = $urandom_range(0, 2);
      fl  = ($urandom_range(0, 31) == 0);
      rb  = !fl && ($urandom_range(0, 11) == 0);
      g   = fl ? 0 : min_int(pop, m_cnt);
      rbt = (m_head + g + $urandom_range(0, m_cnt - g)) % DEPTH;
      drive(pc, pop, fl, rb, rbt);
      set_probe($urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1), $urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
